// File: rtl/prng_stream_reader.sv
// prng_stream_reader: discards a warm-up window of PRNG words, rejects immediate repeats,
// buffers accepted 128-bit words in a FIFO and serves them LSB slice first over valid/ready.
module prng_stream_reader #(
    parameter int OUT_W  = 32,
    parameter int DEPTH  = 4,
    parameter int WARMUP = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [127:0]               random_in,
    input  logic                       enable,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [OUT_W-1:0]           out_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic [15:0]                drops,
    output logic                       stuck,
    input  logic                       stuck_clr
);
    localparam int NS = 128 / OUT_W;
    localparam int AW = $clog2(DEPTH);
    localparam int IW = NS > 1 ? $clog2(NS) : 1;
    localparam int WW = WARMUP > 1 ? $clog2(WARMUP) : 1;

    typedef enum logic {WARM, RUN} state_t;

    state_t         state, state_nx;
    logic [WW-1:0]  wcnt;
    logic [IW-1:0]  idx;
    logic [AW-1:0]  wptr, rptr;
    logic [127:0]   mem [DEPTH];
    logic [127:0]   prev, head;
    logic           prev_v, sample, rep, full, push, drop, hs, pop;

    always_comb begin
        state_nx = (state == WARM && enable && wcnt == WW'(WARMUP - 1)) ? RUN : state;
    end

    assign sample    = state == RUN && enable;
    assign rep       = sample && prev_v && random_in == prev;
    // full uses the registered level, so a same-cycle pop never frees room
    assign full      = level == (AW + 1)'(DEPTH);
    assign push      = sample && !rep && !full;
    assign drop      = sample && !rep && full;
    assign out_valid = level != '0;
    assign hs        = out_valid && out_ready;
    assign pop       = hs && idx == IW'(NS - 1);
    assign head      = mem[rptr];
    assign out_data  = out_valid ? head[32'(idx) * OUT_W +: OUT_W] : '0;

    always_ff @(posedge clk) begin
        if (push && !rst) mem[wptr] <= random_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= WARM;
            wcnt   <= '0;
            idx    <= '0;
            wptr   <= '0;
            rptr   <= '0;
            level  <= '0;
            prev   <= '0;
            prev_v <= 1'b0;
            stuck  <= 1'b0;
            drops  <= '0;
        end else begin
            state <= state_nx;
            if (state == WARM && enable) wcnt <= wcnt + WW'(1);
            if (hs) idx <= pop ? '0 : idx + IW'(1);
            if (push) wptr <= wptr + AW'(1);
            if (pop) rptr <= rptr + AW'(1);
            level <= (push && !pop) ? level + (AW + 1)'(1) :
                     (pop && !push) ? level - (AW + 1)'(1) : level;
            if (sample) begin
                prev   <= random_in;
                prev_v <= 1'b1;
            end
            stuck <= rep || (stuck && !stuck_clr);
            drops <= drop ? (stuck_clr ? 16'd1 : (drops == 16'hFFFF ? drops : drops + 16'd1)) :
                     (stuck_clr ? 16'd0 : drops);
        end
    end
endmodule

// File: tb/tb_prng_stream_reader.sv
// tb_prng_stream_reader: directed stimulus with a slice scoreboard checked by a negedge monitor.
module tb_prng_stream_reader;
    logic         clk = 0;
    logic         rst = 1;
    logic [127:0] random_in = '0;
    logic         enable = 0;
    logic         out_ready = 0;
    logic         out_valid;
    logic [31:0]  out_data;
    logic [2:0]   level;
    logic [15:0]  drops;
    logic         stuck;
    logic         stuck_clr = 0;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];
    logic [31:0] held;
    logic        held_v = 0;

    prng_stream_reader #(.OUT_W(32), .DEPTH(4), .WARMUP(8)) dut (
        .clk(clk), .rst(rst), .random_in(random_in), .enable(enable),
        .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
        .level(level), .drops(drops), .stuck(stuck), .stuck_clr(stuck_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [127:0] w);
        for (int i = 0; i < 4; i++) exp_q.push_back(w[i*32 +: 32]);
    endtask

    function automatic logic [127:0] mkw(input logic [7:0] n);
        return {n, 24'h3, n, 24'h2, n, 24'h1, n, 24'h0};
    endfunction

    // monitor: every handshake pops one expected slice; a stalled slice must hold
    always @(negedge clk) begin
        if (rst) held_v = 0;
        else begin
            if (held_v && out_valid) check("stall_hold", out_data, held);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("unexpected_slice", out_data, 128'hx);
                else check("slice", out_data, exp_q.pop_front());
            end
            held_v = out_valid && !out_ready;
            held   = out_data;
        end
    end

    initial begin
        logic [127:0] w;
        repeat (3) step();
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_level", level, 0);
        check("rst_stuck", stuck, 0);
        check("rst_drops", drops, 0);

        // warm-up, fill, then drops
        rst = 0; enable = 1;
        for (int k = 1; k <= 12; k++) if (k >= 9) push_exp(128'(k));
        for (int k = 1; k <= 14; k++) begin
            random_in = 128'(k);
            step();
            check("warm_level", level, k <= 8 ? 0 : (k - 8 > 4 ? 4 : k - 8));
            check("warm_drops", drops, k > 12 ? k - 12 : 0);
        end
        check("warm_stuck", stuck, 0);
        check("first_word", out_data, 9);

        // drain with a mid-word stall
        enable = 0;
        for (int i = 0; i < 20; i++) begin
            out_ready = (i == 1 || i == 2) ? 0 : 1;
            step();
        end
        out_ready = 0;
        check("drain_level", level, 0);
        check("drain_q", exp_q.size(), 0);

        // slice order
        w = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        push_exp(w);
        random_in = w; enable = 1;
        step();
        enable = 0;
        check("order_level", level, 1);
        check("order_s0", out_data, 32'hCCDDEEFF);
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("order_level_n", level, i < 3 ? 1 : 0);
        end
        out_ready = 0;

        // repeat detection and clear
        w = {16{8'hA5}};
        push_exp(w);
        random_in = w; enable = 1;
        step();
        check("rep_first_stuck", stuck, 0);
        step();
        check("rep_stuck", stuck, 1);
        check("rep_level", level, 1);
        enable = 0; stuck_clr = 1;
        step();
        check("clr_stuck", stuck, 0);
        check("clr_drops", drops, 0);
        enable = 1;
        step();
        check("clr_rep_stuck", stuck, 1);
        check("clr_rep_level", level, 1);
        enable = 0; stuck_clr = 0; out_ready = 1;
        repeat (4) step();
        out_ready = 0;
        check("rep_drain_level", level, 0);

        // full boundary
        enable = 1;
        for (int n = 1; n <= 4; n++) begin
            random_in = mkw(8'(n));
            push_exp(mkw(8'(n)));
            step();
        end
        check("full_level", level, 4);
        enable = 0; out_ready = 1;
        repeat (3) step();
        enable = 1; random_in = mkw(5);
        step();
        check("full_drop_level", level, 3);
        check("full_drops", drops, 1);
        enable = 0;
        repeat (4) step();
        check("lvl2", level, 2);
        repeat (3) step();
        enable = 1; random_in = mkw(6);
        push_exp(mkw(6));
        step();
        check("push_pop_level", level, 2);

        // reset mid-stream
        out_ready = 0; random_in = mkw(7);
        step();
        enable = 0;
        check("pre_rst_level", level, 3);
        out_ready = 1;
        step();
        out_ready = 0; rst = 1;
        step();
        exp_q.delete();
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_level", level, 0);
        check("mid_rst_stuck", stuck, 0);
        check("mid_rst_data", out_data, 0);
        rst = 0; enable = 1;
        push_exp(128'd109);
        for (int k = 1; k <= 9; k++) begin
            random_in = 128'(100 + k);
            step();
            check("rewarm_level", level, k == 9 ? 1 : 0);
        end
        enable = 0;
        check("rewarm_first", out_data, 109);
        out_ready = 1;
        repeat (4) step();
        out_ready = 0;
        step();
        check("final_level", level, 0);
        check("final_q", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
